// File: rtl/sigmoid_arbiter.sv
// Round-robin front end that time-shares one hard-sigmoid evaluator among N_REQ
// score producers and returns QFRAC probabilities tagged with the requester index.
module sigmoid_arbiter #(
   parameter int N_REQ  = 4,
   parameter int W      = 8,
   parameter int FRAC   = 6,
   parameter int SHIFT  = 9,
   parameter int CLIP_X = 4,
   parameter int IDW    = $clog2(N_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*(W+5)-1:0]   req_z,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [W-1:0]             out_p,
   output logic [IDW-1:0]           out_id,
   output logic                     busy
);

   localparam int ZW    = W + 5;
   localparam int P_ONE = 2 ** FRAC;
   localparam int P_MID = 2 ** (FRAC - 1);
   localparam int SLOPE = 2 ** (FRAC - 3);

   typedef enum logic [1:0] {S_IDLE, S_EVAL, S_OUT} state_e;

   state_e                state_q, state_d;
   logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
   logic signed [ZW-1:0]  z_q, z_d;
   logic [IDW-1:0]        id_q, id_d;
   logic [W-1:0]          out_p_q, out_p_d;
   logic [IDW-1:0]        out_id_q, out_id_d;
   logic                  out_valid_q, out_valid_d;

   logic                  arb_en;
   logic                  grant_found;
   logic [IDW-1:0]        grant_idx;
   int                    scan_idx;

   logic signed [ZW-1:0]  x_s;
   int                    x_int;
   int                    p_int;
   logic [W-1:0]          sig_p;

   // First valid requester at or after rr_ptr, wrapping around.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = 0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx = (int'(rr_ptr_q) + k) % N_REQ;
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(scan_idx);
         end
      end
   end

   always_comb begin
      x_s   = z_q >>> SHIFT;
      x_int = int'(x_s);
      p_int = P_MID + x_int * SLOPE;
      if (x_int <= -CLIP_X)      p_int = 0;
      else if (x_int >= CLIP_X)  p_int = P_ONE;
      else if (p_int < 0)        p_int = 0;
      else if (p_int > P_ONE)    p_int = P_ONE;
      sig_p = W'(p_int);
   end

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      z_d         = z_q;
      id_d        = id_q;
      out_p_d     = out_p_q;
      out_id_d    = out_id_q;
      out_valid_d = out_valid_q;
      arb_en      = 1'b0;
      req_ready   = '0;

      case (state_q)
         S_IDLE: arb_en = 1'b1;
         S_EVAL: begin
            out_p_d     = sig_p;
            out_id_d    = id_q;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               arb_en      = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // The accept in OUT shares the cycle with the result transfer.
      if (arb_en && grant_found && !rst) begin
         req_ready[grant_idx] = 1'b1;
         z_d      = req_z[int'(grant_idx)*ZW +: ZW];
         id_d     = grant_idx;
         rr_ptr_d = IDW'((int'(grant_idx) + 1) % N_REQ);
         state_d  = S_EVAL;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         // NOTE: datapath registers are reset as well, so a reset discards any captured or held result.
         z_q         <= '0;
         id_q        <= '0;
         out_p_q     <= '0;
         out_id_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         z_q         <= z_d;
         id_q        <= id_d;
         out_p_q     <= out_p_d;
         out_id_q    <= out_id_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_p     = out_p_q;
   assign out_id    = out_id_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/sigmoid_arbiter.md
# sigmoid_arbiter

Time-shares one `sigmoid_fixed` hard-sigmoid unit among `N_REQ` score producers, such as per-class `mlp_output_score` lanes. Each requester offers a raw signed score over a valid/ready handshake. A round-robin arbiter accepts one score at a time, registers it, evaluates the sigmoid and presents the QFRAC probability tagged with the requester index on a single backpressured output port. The block sits between the MLP score stage and the O/X decision logic.

## Interface
- `N_REQ`, 4: number of requesters (2..8)
- `W`, 8: probability width; score width is `W+5`
- `FRAC`, 6: QFRAC fraction bits (1.0 = 64)
- `SHIFT`, 9: score pre-scale, x = z >>> SHIFT
- `CLIP_X`, 4: linear region bound
- `IDW`, $clog2(N_REQ): index width (derived)

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  N_REQ  score offered, bit i = requester i
- `req_z`  in  N_REQ*(W+5)  signed scores, requester i at bits [i*(W+5) +: W+5]
- `req_ready`  out  N_REQ  accept strobe; at most one bit high
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts result
- `out_p`  out  W  QFRAC probability, 0..2^FRAC
- `out_id`  out  IDW  requester index of `out_p`
- `busy`  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, EVAL, OUT.
- IDLE:
  - If any `req_valid` is high, grant g, drive `req_ready[g]`=1 combinationally and capture `z_reg`<=`req_z[g]` and `id_reg`<=g.
  - Next state EVAL; otherwise stay in IDLE.
- EVAL:
  - `sigmoid_fixed` evaluates `z_reg` combinationally.
  - Register `out_p`, `out_id`=`id_reg` and `out_valid`<=1. Next state OUT.
  - All `req_ready` are 0.
- OUT:
  - Hold `out_p`/`out_id`/`out_valid` stable while `out_ready`=0.
  - On `out_ready`=1, the transfer completes. In the same cycle, arbitrate exactly as in IDLE:
    - if a grant occurs, capture and go to EVAL (`out_valid`<=0);
    - else go to IDLE (`out_valid`<=0).
  - While `out_ready`=0, all `req_ready` are 0.
- Round robin:
  - Pointer `rr_ptr` (IDW bits) resets to 0.
  - Grant is the first i with `req_valid[i]`=1, scanning rr_ptr, rr_ptr+1, …, N_REQ-1, 0, …, wrapping.
  - On grant, `rr_ptr`<=(g+1) mod N_REQ. No grant leaves `rr_ptr` unchanged.
- Sigmoid arithmetic (signed):
  - x = z_reg >>> SHIFT (arithmetic shift).
  - x <= -CLIP_X gives p=0; x >= CLIP_X gives p=2^FRAC.
  - Otherwise p = 2^(FRAC-1) + x*2^(FRAC-3), clamped to [0, 2^FRAC].
- A requester that drops `req_valid` before being granted loses nothing and incurs no state change. Requesters must hold `req_z` stable while `req_valid`=1.

## Timing
- Reset values (asynchronous): state=IDLE, `out_valid`=0, `out_p`=0, `out_id`=0, `rr_ptr`=0, `z_reg`=0, `id_reg`=0, `busy`=0. `req_ready`=0 while `rst`=1.
- Reset asserted mid-operation discards any captured or held result. The first grant after release starts from requester 0.
- Latency: accept in cycle T (`req_ready` high), so `out_valid`=1 from cycle T+2.
- Throughput: with `out_ready` tied high, one result every 2 cycles.
- Simultaneous `out_ready` and new request in OUT: the result transfer and the next accept occur in the same cycle, and the next result is valid 2 cycles later.
- `out_p`/`out_id` change only on the EVAL→OUT edge.

## Test plan
- Single request, default params: `req_valid`=0001, z=0. `req_ready[0]` pulses once and 2 cycles later `out_valid`=1, `out_p`=32, `out_id`=0.
- Arithmetic points on requester 2:
  - z=512 gives 40; z=2047 gives 56; z=2048 gives 64;
  - z=-1 gives 24; z=-1536 gives 8; z=-2048 gives 0; z=-4096 gives 0.
  - `out_id`=2 in every case.
- Fairness: all four `req_valid` held high, `out_ready`=1. Grant order is 0,1,2,3,0,1 with results every 2 cycles and no `req_ready` overlap.
- Backpressure: `out_ready`=0 for 5 cycles with the result pending. `out_p`/`out_id` stay stable, `req_ready` stays 0 and `busy` stays 1. On `out_ready`=1 the next pending requester is accepted in the same cycle.
- Pointer wrap: grant requester 3, then raise only `req_valid[1]`. Requester 1 is granted, and afterwards `rr_ptr` is 2.
- Reset mid-operation: assert `rst` in the EVAL cycle. Outputs clear immediately with no stale `out_valid`. After release with `req_valid`=1010, requester 1 is granted first.
